// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the nanoLADA multi-cycle control sequencer:
// opcodes, R-type funct codes, immediate-extension codes and FSM states.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_MUL = 6'h18;
    localparam logic [5:0] FN_DIV = 6'h1a;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn,
                                      input logic muldiv_en);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT: ok = 1'b1;
                    FN_MUL, FN_DIV: ok = muldiv_en;
                    default: ok = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_control_mem_watchdog.sv
// Memory-handshake watchdog: counts stalled FETCH/MEM cycles and flags a timeout.
module mem_watchdog #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic clear,
    output logic expired
);
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Fires in the stalled cycle whose increment would bring the count to MEM_TIMEOUT.
    always_comb begin
        expired = (MEM_TIMEOUT != 0) && waiting && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT) for the nanoLADA datapath.
// Define MULTICYCLE_CONTROL_MULDIV_EN to enable multi-cycle MUL/DIV via alu_start/alu_done.
module multicycle_control #(
    parameter int ALU_OPS_W   = 6,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 z_flag,
    input  logic                 mem_ready,
    input  logic                 alu_done,
    output logic                 pc_wr,
    output logic                 ir_wr,
    output logic                 sel_pc,
    output logic                 sel_addpc,
    output logic                 sel_wr,
    output logic                 sel_b,
    output logic                 sel_data,
    output logic                 reg_wr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 mem_addr_sel,
    output logic [1:0]           ext_ops,
    output logic [ALU_OPS_W-1:0] alu_ops,
    output logic                 alu_start,
    output logic                 instr_done,
    output logic                 illegal,
    output logic                 bus_err
);
    import multicycle_control_pkg::*;

`ifdef MULTICYCLE_CONTROL_MULDIV_EN
    localparam logic MULDIV_EN = 1'b1;
`else
    localparam logic MULDIV_EN = 1'b0;
`endif

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d, bus_err_q, bus_err_d, busy_q, busy_d;
    logic       waiting, wd_clear, expired;
    logic       is_rtype, is_muldiv, drive_fields;
    logic [5:0] alu_code;
    logic [1:0] ext_code;

    assign is_rtype  = (opcode == OP_RTYPE);
    assign is_muldiv = MULDIV_EN && is_rtype && ((funct == FN_MUL) || (funct == FN_DIV));

    always_comb begin
        alu_code = 6'h00;
        ext_code = EXT_ZERO;
        case (opcode)
            OP_RTYPE:              alu_code = funct;
            OP_ORI:                alu_code = FN_OR;
            OP_LUI:                begin alu_code = FN_OR;  ext_code = EXT_UPPER; end
            OP_BEQ, OP_BNE:        begin alu_code = FN_SUB; ext_code = EXT_SIGN;  end
            OP_ADDI, OP_LW, OP_SW: begin alu_code = FN_ADD; ext_code = EXT_SIGN;  end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;
        busy_d       = 1'b0;
        drive_fields = 1'b0;
        pc_wr        = 1'b0;
        ir_wr        = 1'b0;
        sel_pc       = 1'b0;
        sel_addpc    = 1'b0;
        sel_wr       = 1'b0;
        sel_b        = 1'b0;
        sel_data     = 1'b0;
        reg_wr       = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr_sel = 1'b0;
        ext_ops      = EXT_ZERO;
        alu_ops      = '0;
        alu_start    = 1'b0;
        instr_done   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = ST_DECODE;
                end else if (expired) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_DECODE: begin
                drive_fields = 1'b1;
                if (!is_legal(opcode, funct, MULDIV_EN)) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else if (opcode == OP_J) begin
                    pc_wr      = 1'b1;
                    sel_pc     = 1'b1;
                    instr_done = 1'b1;
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                drive_fields = 1'b1;
                case (opcode)
                    OP_BEQ, OP_BNE: begin
                        sel_addpc  = 1'b1;
                        pc_wr      = (opcode == OP_BEQ) ? z_flag : !z_flag;
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    OP_LW, OP_SW: state_d = ST_MEM;
                    default: begin
                        if (is_muldiv) begin
                            // busy_q marks EXEC cycles after the start pulse
                            alu_start = !busy_q;
                            if (alu_done) begin
                                state_d = ST_WB;
                            end else begin
                                busy_d = 1'b1;
                            end
                        end else begin
                            state_d = ST_WB;
                        end
                    end
                endcase
            end
            ST_MEM: begin
                drive_fields = 1'b1;
                mem_addr_sel = 1'b1;
                mem_rd       = (opcode == OP_LW);
                mem_wr       = (opcode == OP_SW);
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (expired) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_WB: begin
                drive_fields = 1'b1;
                reg_wr       = 1'b1;
                sel_wr       = is_rtype;
                sel_data     = (opcode == OP_LW);
                instr_done   = 1'b1;
                state_d      = ST_FETCH;
            end
            default: ;
        endcase

        if (drive_fields) begin
            alu_ops = ALU_OPS_W'(alu_code);
            ext_ops = ext_code;
            sel_b   = is_rtype;
        end

        // FETCH would otherwise drive mem_rd while reset is held.
        if (!rst_n) begin
            pc_wr        = 1'b0;
            ir_wr        = 1'b0;
            sel_pc       = 1'b0;
            sel_addpc    = 1'b0;
            sel_wr       = 1'b0;
            sel_b        = 1'b0;
            sel_data     = 1'b0;
            reg_wr       = 1'b0;
            mem_rd       = 1'b0;
            mem_wr       = 1'b0;
            mem_addr_sel = 1'b0;
            ext_ops      = EXT_ZERO;
            alu_ops      = '0;
            alu_start    = 1'b0;
            instr_done   = 1'b0;
        end
    end

    assign waiting  = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
    assign wd_clear = mem_ready || (state_d != state_q);

    mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .waiting (waiting),
        .clear   (wd_clear),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            busy_q    <= busy_d;
        end
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle comparison against a phase-level model.
module tb_multicycle_control;

`ifdef MULTICYCLE_CONTROL_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    typedef enum int {P_RST, P_IF, P_ID, P_EX, P_MA, P_WB, P_HALT} ph_e;

    typedef struct packed {
        logic       pc_wr, ir_wr, sel_pc, sel_addpc, sel_wr, sel_b, sel_data, reg_wr;
        logic       mem_rd, mem_wr, mem_addr_sel;
        logic [1:0] ext_ops;
        logic [5:0] alu_ops;
        logic       alu_start, instr_done, illegal, bus_err;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic       z_flag = 1'b0, mem_ready = 1'b0, alu_done = 1'b0;
    logic       pc_wr, ir_wr, sel_pc, sel_addpc, sel_wr, sel_b, sel_data, reg_wr;
    logic       mem_rd, mem_wr, mem_addr_sel, alu_start, instr_done, illegal, bus_err;
    logic [1:0] ext_ops;
    logic [5:0] alu_ops;
    outs_t      dut_o, exp_o;

    ph_e        exp_ph;
    logic       chk_en = 1'b0;
    logic       m_illegal = 1'b0, m_buserr = 1'b0;
    int         n_vec = 0, n_err = 0, n_cyc = 0, lat_seen = 0;
    logic [5:0] exec_alu;

    multicycle_control #(.ALU_OPS_W(6), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .z_flag(z_flag),
        .mem_ready(mem_ready), .alu_done(alu_done), .pc_wr(pc_wr), .ir_wr(ir_wr),
        .sel_pc(sel_pc), .sel_addpc(sel_addpc), .sel_wr(sel_wr), .sel_b(sel_b),
        .sel_data(sel_data), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr_sel(mem_addr_sel), .ext_ops(ext_ops), .alu_ops(alu_ops),
        .alu_start(alu_start), .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err)
    );

    assign dut_o = {pc_wr, ir_wr, sel_pc, sel_addpc, sel_wr, sel_b, sel_data, reg_wr,
                    mem_rd, mem_wr, mem_addr_sel, ext_ops, alu_ops,
                    alu_start, instr_done, illegal, bus_err};

    always #5 clk = ~clk;

    function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: case (fn)
                       6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2a: return 1'b1;
                       6'h18, 6'h1a: return MD;
                       default: return 1'b0;
                   endcase
            6'h02, 6'h04, 6'h05, 6'h08, 6'h0d, 6'h0f, 6'h23, 6'h2b: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Expected outputs for one cycle spent in a given phase of an instruction.
    function automatic outs_t model(input ph_e ph, input logic [5:0] op, input logic [5:0] fn,
                                   input logic z, input logic rdy, input logic first);
        outs_t o;
        o = '0;
        if (ph inside {P_ID, P_EX, P_MA, P_WB}) begin
            o.sel_b = (op == 6'h00);
            case (op)
                6'h00:                o.alu_ops = fn;
                6'h0d, 6'h0f:         o.alu_ops = 6'h25;
                6'h04, 6'h05:         o.alu_ops = 6'h22;
                6'h08, 6'h23, 6'h2b:  o.alu_ops = 6'h20;
                default:              o.alu_ops = 6'h00;
            endcase
            case (op)
                6'h08, 6'h23, 6'h2b, 6'h04, 6'h05: o.ext_ops = 2'b01;
                6'h0f:                             o.ext_ops = 2'b10;
                default:                           o.ext_ops = 2'b00;
            endcase
        end
        case (ph)
            P_IF: begin o.mem_rd = 1'b1; o.ir_wr = rdy; o.pc_wr = rdy; end
            P_ID: if (op == 6'h02) begin o.pc_wr = 1'b1; o.sel_pc = 1'b1; o.instr_done = 1'b1; end
            P_EX: begin
                if (op == 6'h04 || op == 6'h05) begin
                    o.sel_addpc  = 1'b1;
                    o.pc_wr      = (op == 6'h04) ? z : !z;
                    o.instr_done = 1'b1;
                end
                if (MD && op == 6'h00 && (fn == 6'h18 || fn == 6'h1a)) o.alu_start = first;
            end
            P_MA: begin
                o.mem_addr_sel = 1'b1;
                o.mem_rd       = (op == 6'h23);
                o.mem_wr       = (op == 6'h2b);
                o.instr_done   = (op == 6'h2b) && rdy;
            end
            P_WB: begin
                o.reg_wr = 1'b1; o.sel_wr = (op == 6'h00);
                o.sel_data = (op == 6'h23); o.instr_done = 1'b1;
            end
            default: ;
        endcase
        o.illegal = m_illegal;
        o.bus_err = m_buserr;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic cyc(input ph_e ph, input logic rdy, input logic ad, input logic first);
        mem_ready = rdy;
        alu_done  = ad;
        exp_ph    = ph;
        exp_o     = model(ph, opcode, funct, z_flag, rdy, first);
        chk_en    = 1'b1;
        @(posedge clk); #1;
        chk_en    = 1'b0;
    endtask

    task automatic begin_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode = op; funct = fn; z_flag = z;
        n_cyc = 0; lat_seen = 0; exec_alu = 6'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; m_illegal = 1'b0; m_buserr = 1'b0;
        begin_instr(6'h00, 6'h00, 1'b0);
        cyc(P_RST, 1'b0, 1'b0, 1'b0);
        cyc(P_RST, 1'b1, 1'b1, 1'b0);
        chk("reset_outputs", 32'(dut_o), 32'h0);
        rst_n = 1'b1;
    endtask

    // fw/mw: wait cycles in FETCH/MEM; exn: EXEC cycles for MUL/DIV (alu_done on the last).
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int fw, input int mw, input int exn,
                             input int lat, input bit do_alu, input logic [5:0] alu_want);
        begin_instr(op, fn, z);
        for (int i = 0; i < fw; i++) cyc(P_IF, 1'b0, 1'b0, 1'b0);
        cyc(P_IF, 1'b1, 1'b0, 1'b0);
        cyc(P_ID, 1'b0, 1'b0, 1'b0);
        if (!legal(op, fn)) begin
            m_illegal = 1'b1;
            cyc(P_HALT, 1'b1, 1'b1, 1'b0);
            cyc(P_HALT, 1'b0, 1'b0, 1'b0);
            cyc(P_HALT, 1'b1, 1'b0, 1'b0);
        end else if (op != 6'h02) begin
            if (exn > 0) begin
                for (int i = 0; i < exn; i++) cyc(P_EX, 1'b0, (i == exn - 1), (i == 0));
            end else begin
                cyc(P_EX, 1'b0, 1'b0, 1'b1);
            end
            if (op == 6'h23 || op == 6'h2b) begin
                for (int i = 0; i < mw; i++) cyc(P_MA, 1'b0, 1'b0, 1'b0);
                cyc(P_MA, 1'b1, 1'b0, 1'b0);
            end
            if (op != 6'h04 && op != 6'h05 && op != 6'h2b) cyc(P_WB, 1'b0, 1'b0, 1'b0);
        end
        chk({name, "_latency"}, 32'(lat_seen), 32'(lat));
        if (do_alu) chk({name, "_alu_ops"}, 32'(exec_alu), 32'(alu_want));
    endtask

    // Four stalled cycles with MEM_TIMEOUT=4: the fourth raises the fault.
    task automatic timeout_case(input string name, input bit in_mem);
        begin_instr(in_mem ? 6'h23 : 6'h00, 6'h20, 1'b0);
        if (in_mem) begin
            cyc(P_IF, 1'b1, 1'b0, 1'b0);
            cyc(P_ID, 1'b0, 1'b0, 1'b0);
            cyc(P_EX, 1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 4; i++) cyc(in_mem ? P_MA : P_IF, 1'b0, 1'b0, 1'b0);
        m_buserr = 1'b1;
        cyc(P_HALT, 1'b0, 1'b0, 1'b0);
        cyc(P_HALT, 1'b1, 1'b0, 1'b0);
        chk({name, "_bus_err"}, 32'(bus_err), 32'h1);
        chk({name, "_latency"}, 32'(lat_seen), 32'h0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    n_cyc++;
                    if (dut_o.instr_done && lat_seen == 0) lat_seen = n_cyc;
                    if (exp_ph == P_EX) exec_alu = alu_ops;
                    n_vec++;
                    if (dut_o !== exp_o) begin
                        n_err++;
                        $display("FAIL cycle %s op=%h fn=%h: got %h, expected %h",
                                 exp_ph.name(), opcode, funct, dut_o, exp_o);
                    end
                end
            end
        join_none

        @(posedge clk); #1;
        do_reset();

        run_instr("ori",  6'h0d, 6'h00, 1'b0, 0, 0, 0, 4, 1'b1, 6'h25);
        run_instr("add",  6'h00, 6'h20, 1'b0, 0, 0, 0, 4, 1'b1, 6'h20);
        run_instr("sw",   6'h2b, 6'h00, 1'b0, 0, 0, 0, 4, 1'b1, 6'h20);
        run_instr("lw",   6'h23, 6'h00, 1'b0, 0, 0, 0, 5, 1'b1, 6'h20);
        run_instr("beq1", 6'h04, 6'h00, 1'b1, 0, 0, 0, 3, 1'b1, 6'h22);
        run_instr("bne1", 6'h05, 6'h00, 1'b1, 0, 0, 0, 3, 1'b1, 6'h22);
        run_instr("beq0", 6'h04, 6'h00, 1'b0, 0, 0, 0, 3, 1'b1, 6'h22);
        run_instr("bne0", 6'h05, 6'h00, 1'b0, 0, 0, 0, 3, 1'b1, 6'h22);
        // J retires from DECODE: FETCH + DECODE.
        run_instr("j",    6'h02, 6'h00, 1'b0, 0, 0, 0, 2, 1'b0, 6'h00);
        run_instr("lui",  6'h0f, 6'h00, 1'b0, 0, 0, 0, 4, 1'b1, 6'h25);
        run_instr("addi", 6'h08, 6'h00, 1'b0, 0, 0, 0, 4, 1'b1, 6'h20);
        run_instr("xor",  6'h00, 6'h26, 1'b0, 0, 0, 0, 4, 1'b1, 6'h26);
        run_instr("slt",  6'h00, 6'h2a, 1'b0, 0, 0, 0, 4, 1'b1, 6'h2a);
        run_instr("lw_w3", 6'h23, 6'h00, 1'b0, 3, 3, 0, 11, 1'b1, 6'h20);
        run_instr("sw_w1", 6'h2b, 6'h00, 1'b0, 0, 1, 0, 5, 1'b1, 6'h20);

`ifdef MULTICYCLE_CONTROL_MULDIV_EN
        run_instr("mul", 6'h00, 6'h18, 1'b0, 0, 0, 6, 9, 1'b1, 6'h18);
        run_instr("div_same", 6'h00, 6'h1a, 1'b0, 0, 0, 1, 4, 1'b1, 6'h1a);
`else
        run_instr("mul", 6'h00, 6'h18, 1'b0, 0, 0, 6, 0, 1'b0, 6'h00);
        chk("mul_illegal", 32'(illegal), 32'h1);
        do_reset();
`endif

        run_instr("illop", 6'h3f, 6'h00, 1'b0, 0, 0, 0, 0, 1'b0, 6'h00);
        chk("illop_illegal", 32'(illegal), 32'h1);
        do_reset();

        run_instr("badfn", 6'h00, 6'h21, 1'b0, 0, 0, 0, 0, 1'b0, 6'h00);
        do_reset();

        timeout_case("fetch_to", 1'b0);
        do_reset();
        timeout_case("mem_to", 1'b1);
        do_reset();

        begin_instr(6'h2b, 6'h00, 1'b0);
        cyc(P_IF, 1'b1, 1'b0, 1'b0);
        cyc(P_ID, 1'b0, 1'b0, 1'b0);
        cyc(P_EX, 1'b0, 1'b0, 1'b1);
        cyc(P_MA, 1'b0, 1'b0, 1'b0);
        mem_ready = 1'b0;
        #3;
        chk("sw_mem_wr_pre_reset", 32'(mem_wr), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("sw_reset_abort", 32'(dut_o), 32'h0);
        @(posedge clk); #1;
        cyc(P_RST, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        run_instr("add_after_rst", 6'h00, 6'h20, 1'b0, 0, 0, 0, 4, 1'b1, 6'h20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
